serial_addsub: RTL and testbench

- Parametrised bit-serial adder/subtractor: one bit per clock, LSB first, through a single one-bit full-adder cell and a registered carry.
- Used where area matters more than latency, e.g. accumulate/compare paths in low-rate control datapaths.
- Adds what a combinational full adder lacks: generic width, subtract mode, signed-overflow flag and a start/done handshake.

---
 rtl/serial_addsub_pkg.sv | 16 +
 rtl/full_adder.sv | 13 +
 rtl/serial_addsub.sv | 135 +++++++++++++
 tb/tb_serial_addsub.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the counter-width helper derived from the operand width.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must hold 0..WIDTH-1 with headroom so it never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell shared across datapaths.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: processes one bit per clock, LSB first, through
// a single full-adder cell with a registered carry. Subtraction is a + ~b + 1,
// the +1 coming from presetting the carry register.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int                CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MSB_IN = CNT_W'(WIDTH - 2);

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("serial_addsub: WIDTH must be in 2..64");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic               r_c_msb_in;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_s;
  logic               w_c;
  logic [WIDTH-1:0]   w_res_next;

  full_adder u_fa (
    .a    (r_op_a[0]),
    .b    (r_op_b[0]),
    .c    (r_carry),
    .sum  (w_s),
    .cout (w_c)
  );

  // Result register after this bit is shifted in from the top.
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};

  // Control FSM plus serial datapath; all outputs come straight from registers.
  // NOTE: every state element here uses <= so all registers update together
  // from pre-edge values; a blocking = would let later lines see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_c_msb_in <= 1'b0;
      r_cnt      <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end

        RUN: begin
          r_res   <= w_res_next;
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          // Carry out of bit WIDTH-2 is the carry into the MSB, needed for ovf.
          if (r_cnt == CNT_MSB_IN) begin
            r_c_msb_in <= w_c;
          end
          if (r_cnt == CNT_LAST) begin
            r_sum   <= w_res_next;
            r_cout  <= w_c;
            r_ovf   <= r_c_msb_in ^ w_c;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: 8-bit and 16-bit instances, directed
// vectors plus random operands checked against an arithmetic reference model.
module tb_serial_addsub;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ready8, busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ready16, busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  // Reference: plain integer arithmetic, unsigned and signed views.
  function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input bit sub);
    res_t    r;
    longint  mask, half, ua, ub, sa, sb, ur, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= half) ? ua - 2 * half : ua;
    sb = (ub >= half) ? ub - 2 * half : ub;
    ur = sub ? ua - ub : ua + ub;
    sr = sub ? sa - sb : sa + sb;
    r.sum  = 64'(ur & mask);
    r.cout = sub ? (ua >= ub) : (ur >= 2 * half);
    r.ovf  = (sr >= half) || (sr < -half);
    return r;
  endfunction

  function automatic res_t dut_res(input int w);
    res_t r;
    r.sum = '0;
    if (w == 8) begin
      r.sum[7:0] = sum8;  r.cout = cout8;  r.ovf = ovf8;
    end else begin
      r.sum[15:0] = sum16; r.cout = cout16; r.ovf = ovf16;
    end
    return r;
  endfunction

  // {ready, busy, done}
  function automatic logic [2:0] dut_ctl(input int w);
    return (w == 8) ? {ready8, busy8, done8} : {ready16, busy16, done16};
  endfunction

  task automatic set_in(input int w, input bit st, input logic [63:0] a,
                        input logic [63:0] b, input bit sub);
    if (w == 8) begin
      start8 = st;  a8 = a[7:0];   b8 = b[7:0];   sub8 = sub;
    end else begin
      start16 = st; a16 = a[15:0]; b16 = b[15:0]; sub16 = sub;
    end
  endtask

  // One operation from an idle DUT; caller is at a negedge with ready=1.
  // Optional poke: a stray start with other operands during RUN.
  task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input bit sub, input string name, input bit poke);
    res_t exp, got;
    int   k;
    exp = model(w, a, b, sub);
    n_checks++;
    if (dut_ctl(w) !== 3'b100) begin
      n_errors++;
      $display("FAIL %s idle ctl: got %b expected 100", name, dut_ctl(w));
    end
    set_in(w, 1'b1, a, b, sub);
    @(posedge clk);
    #1 set_in(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, ~sub);
    for (k = 1; k <= w + 4; k++) begin
      @(negedge clk);
      if (dut_ctl(w)[0]) break;
      if (poke && k == 2) set_in(w, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, ~sub);
      if (poke && k == 3) set_in(w, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, sub);
    end
    n_checks++;
    if (k != w + 1) begin
      n_errors++;
      $display("FAIL %s latency: done at cycle %0d expected %0d", name, k, w + 1);
    end
    got = dut_res(w);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s result: sum/cout/ovf got %h/%b/%b expected %h/%b/%b",
               name, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
    end
    n_checks++;
    if (dut_ctl(w) !== 3'b011) begin
      n_errors++;
      $display("FAIL %s done ctl: got %b expected 011", name, dut_ctl(w));
    end
    @(negedge clk);
    n_checks++;
    if (dut_ctl(w) !== 3'b100 || dut_res(w) !== exp) begin
      n_errors++;
      $display("FAIL %s after done: ctl %b sum %h, expected ctl 100 sum %h held",
               name, dut_ctl(w), dut_res(w).sum, exp.sum);
    end
  endtask

  task automatic test_reset();
    res_t zero;
    zero = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int w = 8; w <= 16; w += 8) begin
      n_checks++;
      if (dut_ctl(w) !== 3'b100 || dut_res(w) !== zero) begin
        n_errors++;
        $display("FAIL reset w%0d: ctl %b sum %h cout %b ovf %b, expected ctl 100 all zero",
                 w, dut_ctl(w), dut_res(w).sum, dut_res(w).cout, dut_res(w).ovf);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(8, 64'h3C, 64'h45, 1'b0, "add_3c_45", 1'b0);
    run_op(8, 64'h10, 64'h20, 1'b1, "sub_10_20", 1'b0);
    run_op(8, 64'h20, 64'h10, 1'b1, "sub_20_10", 1'b0);
    run_op(8, 64'hFF, 64'h01, 1'b0, "wrap_ff_01", 1'b0);
    run_op(16, 64'h7FFF, 64'h0001, 1'b0, "ovf16_7fff_1", 1'b0);
    run_op(16, 64'h8000, 64'h0001, 1'b1, "ovf16_8000_m1", 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_op(8, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rand8", 1'b0);
      run_op(16, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rand16", 1'b0);
    end
  endtask

  task automatic test_ignore_start();
    run_op(8, 64'h5A, 64'h77, 1'b1, "ignore8", 1'b1);
    run_op(16, 64'h1234, 64'hFEDC, 1'b0, "ignore16", 1'b1);
  endtask

  // start held high: each new operation accepted on the first IDLE edge.
  task automatic test_back_to_back();
    logic [63:0] va[3], vb[3];
    bit          vs[3];
    res_t        exp;
    int          k, gap;
    for (int i = 0; i < 3; i++) begin
      va[i] = {$urandom, $urandom};
      vb[i] = {$urandom, $urandom};
      vs[i] = 1'($urandom);
    end
    set_in(8, 1'b1, va[0], vb[0], vs[0]);
    for (int i = 0; i < 3; i++) begin
      gap = (i == 0) ? 9 : 10;
      for (k = 1; k <= 16; k++) begin
        @(negedge clk);
        if (done8) break;
      end
      n_checks++;
      if (k != gap) begin
        n_errors++;
        $display("FAIL b2b[%0d] spacing: done after %0d cycles expected %0d", i, k, gap);
      end
      exp = model(8, va[i], vb[i], vs[i]);
      n_checks++;
      if (dut_res(8) !== exp) begin
        n_errors++;
        $display("FAIL b2b[%0d] result: sum/cout/ovf got %h/%b/%b expected %h/%b/%b",
                 i, sum8, cout8, ovf8, exp.sum[7:0], exp.cout, exp.ovf);
      end
      if (i < 2) set_in(8, 1'b1, va[i + 1], vb[i + 1], vs[i + 1]);
      else       set_in(8, 1'b0, 64'h0, 64'h0, 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    res_t zero;
    bit   saw_done;
    zero = '0;
    run_op(8, 64'hC3, 64'h5A, 1'b0, "pre_reset", 1'b0);
    set_in(8, 1'b1, 64'h5A, 64'h33, 1'b0);
    @(posedge clk);
    #1 set_in(8, 1'b0, 64'h0, 64'h0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_ctl(8) !== 3'b100 || dut_res(8) !== zero) begin
      n_errors++;
      $display("FAIL midreset async: ctl %b sum %h cout %b ovf %b, expected ctl 100 all zero",
               dut_ctl(8), sum8, cout8, ovf8);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset done: got done pulse, expected none");
    end
    run_op(8, 64'h01, 64'h01, 1'b0, "post_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
